// File: rtl/noc_credit_sender_pkg.sv
// Shared definitions for the NoC credit sender slice.
// Holds the default flit width, the FIFO depth exponent and the credit helper
// so the sender and the downstream circ_fifo always agree on buffer slots.
package noc_credit_sender_pkg;

  // Default flit width, must match the feeding circ_fifo.
  localparam int unsigned NOC_DATA_W       = 32'd8;
  // Depth exponent of the circ_fifo instances on each link.
  localparam int unsigned NOC_FIFO_DEPTH_W = 32'd2;

  // A circ_fifo of 2**depth_w entries keeps one slot free, so it can hold
  // 2**depth_w - 1 flits; that is the credit count the sender starts with.
  function automatic int unsigned noc_credits(input int unsigned depth_w);
    return (32'd1 << depth_w) - 32'd1;
  endfunction

  localparam int unsigned NOC_CREDITS_DEFAULT = noc_credits(NOC_FIFO_DEPTH_W);

  // Net update applied to a credit counter in one cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_DEC  = 2'd1,
    CNT_INC  = 2'd2
  } cnt_op_t;

endpackage

// File: rtl/noc_credit_counter.sv
// Up/down credit counter with reset value, saturation at both ends and a
// sticky error flag raised on any attempt to move past a limit.
// Increment and decrement in the same cycle cancel out.
module noc_credit_counter
  import noc_credit_sender_pkg::*;
#(
  parameter int unsigned WIDTH    = 32'd2,
  parameter int unsigned MAX_VAL  = 32'd3,
  parameter int unsigned INIT_VAL = MAX_VAL
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             err_o
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_C = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = WIDTH'(1'b0);
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

  cnt_op_t          op_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic             err_r;
  logic             err_next_s;

  // Reduce the two strobes to a single net operation.
  always_comb begin
    op_s = CNT_HOLD;
    if (inc_i && !dec_i) begin
      op_s = CNT_INC;
    end else if (dec_i && !inc_i) begin
      op_s = CNT_DEC;
    end else begin
      op_s = CNT_HOLD;
    end
  end

  // Next count with saturation; a blocked move latches the error flag.
  always_comb begin
    count_next_s = count_r;
    err_next_s   = err_r;
    case (op_s)
      CNT_INC: begin
        if (count_r == MAX_C) begin
          err_next_s = 1'b1;
        end else begin
          count_next_s = count_r + ONE_C;
        end
      end
      CNT_DEC: begin
        if (count_r == ZERO_C) begin
          err_next_s = 1'b1;
        end else begin
          count_next_s = count_r - ONE_C;
        end
      end
      CNT_HOLD: begin
        count_next_s = count_r;
      end
      default: begin
        count_next_s = count_r;
      end
    endcase
  end

  // Counter and sticky error state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= INIT_C;
      err_r   <= 1'b0;
    end else begin
      count_r <= count_next_s;
      err_r   <= err_next_s;
    end
  end

  assign count_o = count_r;
  assign err_o   = err_r;

endmodule

// File: rtl/noc_credit_sender.sv
// Output-side drain stage between a router port's circ_fifo and the link.
// Reads the FIFO only while the downstream router has a free slot (credit),
// and drives the link through a two-stage registered valid/data pipeline.
// Optional build macro NOC_CREDIT_SENDER_STATS_EN adds flit and stall counters.
module noc_credit_sender
  import noc_credit_sender_pkg::*;
#(
  parameter  int unsigned DATA_W   = NOC_DATA_W,
  parameter  int unsigned CREDITS  = NOC_CREDITS_DEFAULT,
  localparam int unsigned CREDIT_W = $clog2(CREDITS + 32'd1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                fifo_empty_i,
  input  logic [DATA_W-1:0]   fifo_data_i,
  output logic                fifo_rd_en_o,
  input  logic                credit_i,
  output logic                valid_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [CREDIT_W-1:0] credits_o,
  output logic                credit_err_o
`ifdef NOC_CREDIT_SENDER_STATS_EN
  ,
  output logic [15:0]         flit_cnt_o,
  output logic [15:0]         stall_cnt_o
`endif
);

  localparam logic [CREDIT_W-1:0] NO_CREDITS_C = CREDIT_W'(1'b0);

  logic [CREDIT_W-1:0] credits_s;
  logic                credit_err_s;
  logic                rd_en_s;
  logic                rd_r;
  logic                valid_r;
  logic [DATA_W-1:0]   data_r;

  // Issue a read only with a reserved credit; credit_i never feeds this path,
  // and reset forces the strobe low so the FIFO is untouched while held.
  always_comb begin
    rd_en_s = 1'b0;
    if (rst_ni && en_i && !fifo_empty_i && (credits_s != NO_CREDITS_C)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Credits are consumed at issue time and returned by credit_i pulses.
  noc_credit_counter #(
    .WIDTH    (CREDIT_W),
    .MAX_VAL  (CREDITS),
    .INIT_VAL (CREDITS)
  ) u_credit_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (credit_i),
    .dec_i   (rd_en_s),
    .count_o (credits_s),
    .err_o   (credit_err_s)
  );

  // Two-stage link pipeline: FIFO data is valid the cycle after the read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_r    <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else begin
      rd_r    <= rd_en_s;
      valid_r <= rd_r;
      if (rd_r) begin
        data_r <= fifo_data_i;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign fifo_rd_en_o = rd_en_s;
  assign valid_o      = valid_r;
  assign data_o       = data_r;
  assign credits_o    = credits_s;
  assign credit_err_o = credit_err_s;

`ifdef NOC_CREDIT_SENDER_STATS_EN
  logic [15:0] flit_cnt_r;
  logic [15:0] stall_cnt_r;
  logic        stall_s;

  // A stall is pending traffic held back only by the lack of credits.
  always_comb begin
    stall_s = 1'b0;
    if (en_i && !fifo_empty_i && (credits_s == NO_CREDITS_C)) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Flit counter wraps; stall counter saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flit_cnt_r  <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else begin
      if (valid_r) begin
        flit_cnt_r <= flit_cnt_r + 16'h0001;
      end else begin
        flit_cnt_r <= flit_cnt_r;
      end
      if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign flit_cnt_o  = flit_cnt_r;
  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_noc_credit_sender.sv
// Directed bench for noc_credit_sender with a small FIFO model, a credit
// reference model and a scoreboard of expected link flits with due cycles.
module tb_noc_credit_sender;
  import noc_credit_sender_pkg::*;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CREDITS  = 3;
  localparam int unsigned CREDIT_W = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                en_i;
  logic                fifo_empty_i;
  logic [DATA_W-1:0]   fifo_data_i = 8'h00;
  logic                fifo_rd_en_o;
  logic                credit_i;
  logic                valid_o;
  logic [DATA_W-1:0]   data_o;
  logic [CREDIT_W-1:0] credits_o;
  logic                credit_err_o;
`ifdef NOC_CREDIT_SENDER_STATS_EN
  logic [15:0]         flit_cnt_o;
  logic [15:0]         stall_cnt_o;
`endif

  noc_credit_sender #(
    .DATA_W  (DATA_W),
    .CREDITS (CREDITS)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .credit_i     (credit_i),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .credits_o    (credits_o),
    .credit_err_o (credit_err_o)
`ifdef NOC_CREDIT_SENDER_STATS_EN
    ,
    .flit_cnt_o   (flit_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Upstream FIFO model: read data appears the cycle after the read strobe.
  logic [DATA_W-1:0] mem [0:63];
  int head = 0;
  int tail = 0;
  assign fifo_empty_i = (head == tail);

  always @(posedge clk_i) begin
    if (fifo_rd_en_o === 1'b1) begin
      fifo_data_i <= mem[head];
      head        <= head + 1;
    end
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_cr   = CREDITS;
  logic exp_err  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_fifo(input logic [DATA_W-1:0] d);
    mem[tail] = d;
    tail      = tail + 1;
  endtask

  // One clock cycle: predict issue and credits, advance, then check the link.
  task automatic tick(input logic cr);
    logic exp_rd;
    credit_i = cr;
    #1;
    exp_rd = en_i && (head != tail) && (exp_cr != 0);
    chk("rd_en", {31'd0, fifo_rd_en_o}, {31'd0, exp_rd});
    if (exp_rd) begin
      exp_q.push_back('{data: mem[head], due: cyc + 2});
    end
    if (cr && !exp_rd && (exp_cr == CREDITS)) begin
      exp_err = 1'b1;
    end else begin
      exp_cr = exp_cr - int'(exp_rd) + int'(cr);
    end
    @(posedge clk_i);
    #1;
    cyc++;
    credit_i = 1'b0;
    if ((exp_q.size() != 0) && (exp_q[0].due == cyc)) begin
      chk("valid_hi", {31'd0, valid_o}, 32'd1);
      chk("data", {24'd0, data_o}, {24'd0, exp_q[0].data});
      void'(exp_q.pop_front());
    end else begin
      chk("valid_lo", {31'd0, valid_o}, 32'd0);
    end
    chk("credits", {30'd0, credits_o}, exp_cr);
    chk("credit_err", {31'd0, credit_err_o}, {31'd0, exp_err});
  endtask

  initial begin
    rst_ni   = 1'b0;
    en_i     = 1'b0;
    credit_i = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_credits", {30'd0, credits_o}, 32'd3);
    chk("rst_err", {31'd0, credit_err_o}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Idle with empty FIFO and enable high.
    en_i = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0);

    // Four flits, no returns: three go, the fourth waits for a credit.
    push_fifo(8'hA1);
    push_fifo(8'hA2);
    push_fifo(8'hA3);
    push_fifo(8'hA4);
    for (int i = 0; i < 7; i++) tick(1'b0);
    chk("a4_waiting", {31'd0, fifo_empty_i}, 32'd0);
    tick(1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0);

    // Credit return coinciding with an issue at credits=1.
    push_fifo(8'hB1);
    push_fifo(8'hB2);
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1);

    // Overflow credit while idle at full credits: sticky error.
    tick(1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0);

    // Enable dropped after two issues; third flit waits for re-enable.
    push_fifo(8'hC1);
    push_fifo(8'hC2);
    push_fifo(8'hC3);
    tick(1'b0);
    tick(1'b0);
    en_i = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0);
    en_i = 1'b1;
    tick(1'b0);
    push_fifo(8'hD1);
    tick(1'b0);
    tick(1'b0);

    // Asynchronous reset mid-cycle with valid_o high and no credits left.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", {31'd0, valid_o}, 32'd0);
    chk("arst_rd_q", {31'd0, dut.rd_r}, 32'd0);
    chk("arst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
    chk("arst_credits", {30'd0, credits_o}, 32'd3);
    chk("arst_err", {31'd0, credit_err_o}, 32'd0);
`ifdef NOC_CREDIT_SENDER_STATS_EN
    chk("arst_flit_cnt", {16'd0, flit_cnt_o}, 32'd0);
`endif
    exp_q.delete();
    exp_cr  = CREDITS;
    exp_err = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Traffic resumes after reset.
    for (int i = 0; i < 4; i++) tick(1'b0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_credit_sender.md
Name: noc_credit_sender

Overview:
- Output-side drain stage placed directly downstream of a router port's circ_fifo.
- Pops flits from the FIFO only when the downstream router has buffer space, tracked with a credit counter.
- Drives the inter-router link as a registered valid/data pair. Downstream returns one credit pulse per flit it dequeues.
- Guarantees the upstream FIFO never sees a read while empty and the downstream FIFO never sees a write while full.

Parameters:
- DATA_W, 8: flit width; must match the feeding FIFO.
- CREDITS, 3: downstream buffer slots. Default matches a circ_fifo with FIFO_DEPTH_W=2 (N-1 usable slots). Legal range 1..255.
- CREDIT_W, $clog2(CREDITS+1): credit counter width. Localparam, derived, not overridable.

Ports:
- clk_i, input, 1: clock; all state on the rising edge.
- rst_ni, input, 1: reset, asynchronous assert, active-low.
- en_i, input, 1: issue enable; 0 blocks new FIFO reads, in-flight flits still complete.
- fifo_empty_i, input, 1: empty flag of the upstream FIFO.
- fifo_data_i, input, DATA_W: read data of the upstream FIFO. Valid in the cycle after fifo_rd_en_o.
- fifo_rd_en_o, output, 1: FIFO read strobe.
- credit_i, input, 1: one-cycle pulse, downstream returned one slot.
- valid_o, output, 1: flit valid on the link.
- data_o, output, DATA_W: flit on the link.
- credits_o, output, CREDIT_W: current credit count.
- credit_err_o, output, 1: sticky, a credit arrived with the counter already at CREDITS.

Behaviour:
- Reset (async, rst_ni=0) sets:
  - credit count = CREDITS;
  - rd_q = 0, valid_o = 0, data_o = 0, credit_err_o = 0;
  - fifo_rd_en_o = 0 while in reset.
  - Asserting reset mid-transfer discards in-flight flits and restores full credits. Release is synchronous to clk_i.
- Issue: fifo_rd_en_o = en_i && !fifo_empty_i && (credits != 0).
  - Combinational from registered credits plus inputs only; no path from credit_i.
- Credit reservation happens at issue. On each edge: credits_next = credits - fifo_rd_en_o + credit_i.
  - Simultaneous issue and credit: count unchanged.
- Credit overflow: credit_i=1, fifo_rd_en_o=0, credits==CREDITS.
  - Count holds at CREDITS; credit_err_o sets and stays set until reset.
- Pipeline:
  - Stage 1: rd_q <= fifo_rd_en_o.
  - Stage 2: valid_o <= rd_q; when rd_q=1, data_o <= fifo_data_i; otherwise data_o holds its last value.
  - Latency: fifo_rd_en_o at cycle t gives valid_o=1 with the flit at cycle t+2.
- Throughput: one flit per cycle while credits remain and the FIFO is non-empty.
  - With CREDITS=3 and no returns, exactly 3 flits are sent and then fifo_rd_en_o stays 0.
- en_i falling: no new issues from that cycle; up to 2 already-issued flits still appear on valid_o.
- Invariant: credits + (in-flight count) never exceeds CREDITS.

Optional Feature:
- Macro: NOC_CREDIT_SENDER_STATS_EN.
- With the macro defined:
  - Adds output flit_cnt_o, 16 bits: counts valid_o cycles, wraps 0xFFFF -> 0.
  - Adds output stall_cnt_o, 16 bits: counts cycles with en_i && !fifo_empty_i && credits==0; saturates at 0xFFFF.
  - Both reset to 0.
- Without the macro: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared header noc_defines.vh holds:
  - default DATA_W;
  - FIFO_DEPTH_W;
  - the macro NOC_CREDITS(depth_w) = 2**depth_w - 1, so the sender and downstream FIFO always agree.
- One natural sub-module: noc_credit_counter.
  - Parameterised up/down counter with init value, saturation and sticky error.
  - Reused later by the input-side credit return logic.

Test Plan:
- Reset then idle, with fifo_empty_i=1 and en_i=1: fifo_rd_en_o=0, valid_o=0, credits_o=3, credit_err_o=0 for 10 cycles.
- FIFO holds 0xA1,0xA2,0xA3,0xA4 and no credits return: three reads on consecutive cycles; valid_o carries 0xA1,0xA2,0xA3 at t+2..t+4; credits_o=0; 0xA4 stays until credit_i, then appears 2 cycles after the next read.
- Credit pulse in the same cycle as an issue, with credits=1: credits_o stays 1; next cycle another issue is allowed.
- credit_i pulsed with credits=3 and idle: credits_o=3, credit_err_o=1 and stays 1 until rst_ni=0.
- en_i dropped the cycle after two issues: both flits still appear on valid_o; no further fifo_rd_en_o while en_i=0 even with the FIFO non-empty.
- rst_ni asserted asynchronously mid-cycle with valid_o=1 and credits=0: valid_o, rd_q and fifo_rd_en_o go to 0 immediately; credits_o=3. With NOC_CREDIT_SENDER_STATS_EN defined, flit_cnt_o=0.
